fir_feeder: RTL and testbench
=============================

FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sample FIFO entries (power of two, 2..16).
REQ-002 Parameter DONE_TIMEOUT, default 64, maximum cycles waited for fir_done after a launch.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 coef_wr_en  input  1  write coef_wdata into shadow coefficient register coef_addr.
REQ-006 coef_addr  input  4  shadow register index 0..15.
REQ-007 coef_wdata  input  8  coefficient value, signed Q1.7.
REQ-008 cfg_tap_num  input  4  tap count minus one, 0..15; sampled at cfg_start.
REQ-009 cfg_start  input  1  one-cycle request to send a configuration frame to the filter.
REQ-010 s_valid / s_ready / s_data  input / output / input  1 / 1 / 8  upstream sample handshake; transfer when both high.
REQ-011 fir_data_in  output  8  shared config/sample word to the filter.
REQ-012 fir_enable  output  1  one-cycle sample launch strobe.
REQ-013 fir_configuration  output  1  high for the whole configuration frame.
REQ-014 fir_config_data_enable  output  1  qualifies each configuration word.
REQ-015 fir_done  input  1  filter ready for next sample (one-cycle pulse).
REQ-016 cfg_busy  output  1  high while a configuration frame is being sent.
REQ-017 timeout_err  output  1  sticky watchdog error (macro-dependent).
REQ-018 err_clr  input  1  clears timeout_err and leaves ERR.

Function
REQ-019 States: IDLE, CFG_HDR, CFG_COEF, LAUNCH, WAIT, ERR.
REQ-020 IDLE: cfg_start -> CFG_HDR (priority); else FIFO non-empty -> LAUNCH; else stay.
REQ-021 CFG_HDR, 1 cycle: fir_configuration=1, fir_config_data_enable=1, fir_data_in={4'b0, latched tap_num} -> CFG_COEF.
REQ-022 CFG_COEF: tap_num+1 consecutive cycles, fir_configuration=1, fir_config_data_enable=1, fir_data_in=shadow[k], k=0..tap_num ascending; after last word -> IDLE, fir_configuration low the next cycle.
REQ-023 cfg_busy = 1 exactly in CFG_HDR and CFG_COEF; frame length is tap_num+2 cycles.
REQ-024 cfg_start outside IDLE is ignored (not queued).
REQ-025 coef_wr_en during CFG_HDR/CFG_COEF is ignored; otherwise the write takes effect next edge.
REQ-026 LAUNCH, 1 cycle: pop FIFO head, fir_enable=1, fir_data_in=head -> WAIT.
REQ-027 WAIT: fir_done -> IDLE; fir_done in any other state is ignored.
REQ-028 fir_data_in holds its last driven value when not in CFG_HDR/CFG_COEF/LAUNCH; fir_enable and fir_config_data_enable are 0 outside their states.
REQ-029 FIFO: s_ready = not full; push on s_valid&s_ready; same-cycle push and pop legal when not full; pointers wrap modulo FIFO_DEPTH; order preserved.
REQ-030 Minimum launch-to-launch spacing: 3 cycles (LAUNCH, WAIT with fir_done, IDLE).

Reset
REQ-031 rst_n low at any time, mid-frame or mid-wait included, forces IDLE, empties FIFO, all outputs 0 (s_ready 1 once rst_n is high), shadow registers 0, timeout_err 0, no partial frame resumed.

Configuration
REQ-032 Macro FIR_FEEDER_TIMEOUT_EN defined: a cycle counter clears on entry to WAIT; if DONE_TIMEOUT cycles elapse in WAIT without fir_done -> ERR, timeout_err=1; ERR blocks launches and cfg_start; err_clr -> IDLE, timeout_err=0; FIFO contents retained.
REQ-033 Macro undefined: no counter, WAIT waits indefinitely, ERR unreachable, timeout_err constant 0, err_clr ignored.

Verification
REQ-034 Write shadow[0..3]=8'h10,8'h20,8'h30,8'h40, cfg_tap_num=3, pulse cfg_start -> words 8'h03,8'h10,8'h20,8'h30,8'h40 on 5 consecutive cycles, configuration and config_data_enable high for those 5 cycles only.
REQ-035 Push samples 8'h01,8'h02,8'h03; fir_done 2 cycles after each fir_enable -> three fir_enable pulses carrying 8'h01,8'h02,8'h03 in order, each launch waits for fir_done.
REQ-036 Hold fir_done low, push 5 samples with FIFO_DEPTH=4 -> 1 launched, 4 buffered, s_ready low after the 5th push; fir_done then drains all in order.
REQ-037 cfg_start and s_valid in same IDLE cycle -> configuration frame sent first, sample launched after frame ends; cfg_start during WAIT -> no frame.
REQ-038 With FIR_FEEDER_TIMEOUT_EN, no fir_done for 64 cycles -> timeout_err=1, no further fir_enable; err_clr -> next sample launched; without the macro -> no error, launch occurs when fir_done arrives.
REQ-039 Assert rst_n low during CFG_COEF word 2 -> all outputs 0 asynchronously, FIFO empty, next cfg_start sends a full frame from the header.

Source files
------------

// File: rtl/fir_feeder.sv
// Sample/configuration feeder for an external FIR filter: shadow coefficient bank,
// sample FIFO and a sequencer. Optional done-watchdog enabled by FIR_FEEDER_TIMEOUT_EN.
module fir_feeder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coef_wr_en,
    input  logic [3:0] coef_addr,
    input  logic [7:0] coef_wdata,
    input  logic [3:0] cfg_tap_num,
    input  logic       cfg_start,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic [7:0] fir_data_in,
    output logic       fir_enable,
    output logic       fir_configuration,
    output logic       fir_config_data_enable,
    input  logic       fir_done,
    output logic       cfg_busy,
    output logic       timeout_err,
    input  logic       err_clr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, CFG_HDR, CFG_COEF, LAUNCH, WAIT, ERR} state_t;

    state_t state_q, state_d;
    logic [3:0] tap_q, tap_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [15:0][7:0] coef_q, coef_d;
    logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count_q, count_d;
    logic full, empty, push, pop;

    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // s_ready is forced low while reset is asserted so every output reads 0 then.
    assign s_ready = rst_n & ~full;
    assign push    = s_valid & s_ready;
    assign pop     = (state_q == LAUNCH);

    assign cfg_busy               = (state_q == CFG_HDR) || (state_q == CFG_COEF);
    assign fir_configuration      = cfg_busy;
    assign fir_config_data_enable = cfg_busy;
    assign fir_enable             = (state_q == LAUNCH);

`ifdef FIR_FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout_err = (state_q == ERR);
`else
    logic unused_ok;
    assign unused_ok   = err_clr ^ (DONE_TIMEOUT == 0);
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        case (state_q)
            CFG_HDR:  fir_data_in = {4'b0, tap_q};
            CFG_COEF: fir_data_in = coef_q[idx_q];
            LAUNCH:   fir_data_in = mem_q[rd_ptr_q];
            default:  fir_data_in = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        idx_d   = idx_q;
        data_d  = fir_data_in;
`ifdef FIR_FEEDER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    tap_d   = cfg_tap_num;
                    state_d = CFG_HDR;
                end else if (!empty) begin
                    state_d = LAUNCH;
                end
            end
            CFG_HDR: begin
                idx_d   = '0;
                state_d = CFG_COEF;
            end
            CFG_COEF: begin
                if (idx_q == tap_q) state_d = IDLE;
                else                idx_d   = idx_q + 4'd1;
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef FIR_FEEDER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (fir_done) begin
                    state_d = IDLE;
`ifdef FIR_FEEDER_TIMEOUT_EN
                end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ERR: begin
`ifdef FIR_FEEDER_TIMEOUT_EN
                if (err_clr) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Coefficient writes are dropped while a frame is on the wire so it stays coherent.
    always_comb begin
        coef_d = coef_q;
        if (coef_wr_en && !cfg_busy) coef_d[coef_addr] = coef_wdata;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            coef_q   <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            coef_q   <= coef_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FIR_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: cycle table for frames/FIFO/priority, plus hand
// sequences for the done-watchdog (macro-dependent) and mid-frame reset.
module tb_fir_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coef_wr_en;
    logic [3:0] coef_addr;
    logic [7:0] coef_wdata;
    logic [3:0] cfg_tap_num;
    logic       cfg_start;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [7:0] fir_data_in;
    logic       fir_enable;
    logic       fir_configuration;
    logic       fir_config_data_enable;
    logic       fir_done;
    logic       cfg_busy;
    logic       timeout_err;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    fir_feeder #(.FIFO_DEPTH(4), .DONE_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .cfg_tap_num(cfg_tap_num), .cfg_start(cfg_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_data_in(fir_data_in), .fir_enable(fir_enable),
        .fir_configuration(fir_configuration),
        .fir_config_data_enable(fir_config_data_enable),
        .fir_done(fir_done), .cfg_busy(cfg_busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [3:0] tap;
        logic       start;
        logic       sv;
        logic [7:0] sd;
        logic       done;
        logic       en;
        logic       cfg;
        logic       busy;
        logic [7:0] data;
        logic       srdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                       input logic [3:0] tap, input logic start, input logic sv,
                       input logic [7:0] sd, input logic done, input logic en,
                       input logic cfg, input logic [7:0] data, input logic srdy);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.tap = tap; v.start = start;
        v.sv = sv; v.sd = sd; v.done = done; v.en = en; v.cfg = cfg;
        v.busy = cfg; v.data = data; v.srdy = srdy;
        vecs.push_back(v);
    endtask

    task automatic idle_in();
        coef_wr_en = 0; coef_addr = 0; coef_wdata = 0; cfg_tap_num = 0;
        cfg_start = 0; s_valid = 0; s_data = 0; fir_done = 0; err_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic en, input logic cfg,
                           input logic [7:0] data, input logic srdy);
        chk({nm, ".en"},   fir_enable, en);
        chk({nm, ".cfg"},  fir_configuration, cfg);
        chk({nm, ".cde"},  fir_config_data_enable, cfg);
        chk({nm, ".busy"}, cfg_busy, cfg);
        chk({nm, ".data"}, fir_data_in, data);
        chk({nm, ".srdy"}, s_ready, srdy);
    endtask

    initial begin
        int en_seen;
        idle_in();
        rst_n = 0;
        #12;
        chk_out("rst", 0, 0, 8'h00, 0);
        chk("rst.terr", timeout_err, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_out("rst_rel", 0, 0, 8'h00, 1);

        // Coefficient load and 4-tap frame; a write during the header is dropped.
        add(1,0,8'h10, 0,0, 0,0,0, 0,0,8'h00,1);
        add(1,1,8'h20, 0,0, 0,0,0, 0,0,8'h00,1);
        add(1,2,8'h30, 0,0, 0,0,0, 0,0,8'h00,1);
        add(1,3,8'h40, 0,0, 0,0,0, 0,0,8'h00,1);
        add(0,0,0, 3,1, 0,0,0, 0,1,8'h03,1);
        add(1,0,8'h99, 0,0, 0,0,0, 0,1,8'h10,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h20,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h30,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h40,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h40,1);
        // Single-tap frame proves shadow[0] kept 8'h10.
        add(0,0,0, 0,1, 0,0,0, 0,1,8'h00,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h10,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h10,1);
        // Three samples, fir_done two cycles after each launch.
        add(0,0,0, 0,0, 1,8'h01,0, 0,0,8'h10,1);
        add(0,0,0, 0,0, 1,8'h02,0, 1,0,8'h01,1);
        add(0,0,0, 0,0, 1,8'h03,0, 0,0,8'h01,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h01,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'h01,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'h02,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h02,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h02,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'h02,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'h03,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h03,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h03,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'h03,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h03,1);
        // Five pushes with fir_done low: one launched, four buffered, FIFO full.
        add(0,0,0, 0,0, 1,8'hA1,0, 0,0,8'h03,1);
        add(0,0,0, 0,0, 1,8'hA2,0, 1,0,8'hA1,1);
        add(0,0,0, 0,0, 1,8'hA3,0, 0,0,8'hA1,1);
        add(0,0,0, 0,0, 1,8'hA4,0, 0,0,8'hA1,1);
        add(0,0,0, 0,0, 1,8'hA5,0, 0,0,8'hA1,0);
        add(0,0,0, 0,0, 1,8'hEE,0, 0,0,8'hA1,0);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'hA1,0);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'hA2,0);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'hA2,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'hA2,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'hA3,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'hA3,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'hA3,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'hA4,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'hA4,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'hA4,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'hA5,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'hA5,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'hA5,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'hA5,1);
        // cfg_start wins over a same-cycle sample; cfg_start in WAIT is dropped.
        add(0,0,0, 1,1, 1,8'h55,0, 0,1,8'h01,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h10,1);
        add(0,0,0, 0,0, 0,0,0, 0,1,8'h20,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h20,1);
        add(0,0,0, 0,0, 0,0,0, 1,0,8'h55,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h55,1);
        add(0,0,0, 2,1, 0,0,0, 0,0,8'h55,1);
        add(0,0,0, 0,0, 0,0,1, 0,0,8'h55,1);
        add(0,0,0, 0,0, 0,0,0, 0,0,8'h55,1);

        foreach (vecs[i]) begin
            coef_wr_en = vecs[i].wr;  coef_addr = vecs[i].addr; coef_wdata = vecs[i].wd;
            cfg_tap_num = vecs[i].tap; cfg_start = vecs[i].start;
            s_valid = vecs[i].sv; s_data = vecs[i].sd; fir_done = vecs[i].done;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].cfg, vecs[i].data, vecs[i].srdy);
        end
        idle_in();

        // Watchdog: launch 8'h77 with 8'h78 queued, then withhold fir_done.
        s_valid = 1; s_data = 8'h77; tick();
        s_data = 8'h78; tick();
        s_valid = 0;
        chk("wd.launch_en", fir_enable, 1);
        chk("wd.launch_data", fir_data_in, 8'h77);
        en_seen = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (fir_enable) en_seen++;
        end
        chk("wd.err_before", timeout_err, 0);
        tick();
`ifdef FIR_FEEDER_TIMEOUT_EN
        chk("wd.err_set", timeout_err, 1);
`else
        chk("wd.err_set", timeout_err, 0);
`endif
        cfg_start = 1; cfg_tap_num = 1; tick(); cfg_start = 0;
        chk("wd.cfg_blocked", cfg_busy, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (fir_enable) en_seen++;
        end
        chk("wd.no_launch", en_seen, 0);
`ifdef FIR_FEEDER_TIMEOUT_EN
        chk("wd.err_sticky", timeout_err, 1);
        err_clr = 1; tick(); err_clr = 0;
        chk("wd.err_clr", timeout_err, 0);
`else
        err_clr = 1; tick(); err_clr = 0;
        chk("wd.no_err", timeout_err, 0);
        fir_done = 1; tick(); fir_done = 0;
`endif
        tick();
        chk("wd.next_en", fir_enable, 1);
        chk("wd.next_data", fir_data_in, 8'h78);
        tick();
        fir_done = 1; tick(); fir_done = 0;
        chk("wd.idle_en", fir_enable, 0);

        // Reset during CFG_COEF word 2 with a sample queued behind the frame.
        cfg_tap_num = 3; cfg_start = 1; s_valid = 1; s_data = 8'h99; tick();
        cfg_start = 0; s_valid = 0;
        chk("rs.hdr", fir_data_in, 8'h03);
        tick(); tick(); tick();
        chk("rs.word2", fir_data_in, 8'h30);
        rst_n = 0;
        #1;
        chk_out("rs.async", 0, 0, 8'h00, 0);
        chk("rs.terr", timeout_err, 0);
        @(negedge clk);
        rst_n = 1;
        en_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (fir_enable) en_seen++;
        end
        chk("rs.fifo_empty", en_seen, 0);
        chk_out("rs.idle", 0, 0, 8'h00, 1);
        cfg_tap_num = 3; cfg_start = 1; tick(); cfg_start = 0;
        chk_out("rs.hdr2", 0, 1, 8'h03, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("rs.coef%0d", k), 0, 1, 8'h00, 1);
        end
        tick();
        chk_out("rs.end", 0, 0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
